data_input: RTL and testbench
=============================

# data_input

Decimal-to-binary input stage for the processor's IN path, the inverse of the binary-to-BCD display driver. Accepts an 8-digit packed-BCD value plus a sign flag from the board switches or keypad. Converts the value iteratively with reverse double-dabble: shift right, then subtract 3 from any digit ≥ 8. Returns a 32-bit two's-complement word, with a start/done handshake, for the register file write-back.

## Interface
Parameters:
- NUM_DIGITS, 8, number of packed BCD digits on `bcd`.
- BIN_BITS, 27, conversion width; the shift count satisfies 2^BIN_BITS > 10^NUM_DIGITS − 1.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  conversion request; sampled only in IDLE.
- bcd  in  32  packed BCD, digit 0 in bits [3:0], digit 7 in bits [31:28].
- neg  in  1  sign of the entered value; 1 = negative.
- valor  out  32  converted two's-complement result; holds until the next completed conversion.
- pronto  out  1  one-cycle pulse: `valor` and `erro` are valid.
- ocupado  out  1  high from the cycle after `start` is accepted until `pronto` is asserted.
- erro  out  1  the last request contained a nibble > 9; held until the next accepted `start`.

## Operation
- Reset values: `valor` = 0, `pronto` = 0, `ocupado` = 0, `erro` = 0, state IDLE, counter 0.
- **IDLE:**
  - If `start` = 1 and every nibble is ≤ 9: load the shift register with {bcd, BIN_BITS'b0}, latch `neg`, clear the counter and `erro`, then go to CONV.
  - If `start` = 1 and any nibble is > 9: set `erro` = 1, leave `valor` unchanged, go to DONE.
- **CONV:** each cycle, shift the {bcd_part, bin_part} register right by 1. Then, for each of the NUM_DIGITS nibbles of bcd_part, subtract 3 if the nibble is ≥ 8. When the counter reaches BIN_BITS−1, go to FIX. Otherwise increment the counter.
- **FIX:**
  - `valor` = zero-extended bin_part.
  - Negate when the sign feature is enabled (see Configuration), the latched `neg` = 1 and the magnitude is ≠ 0: `valor` = ~mag + 1.
  - −0 yields 0.
  - Go to DONE.
- **DONE:** `pronto` = 1 for this cycle only, then return to IDLE.
- `start` is ignored outside IDLE; there is no queueing.
- `bcd` and `neg` are sampled only at acceptance. Changes during CONV have no effect.
- Reset mid-conversion aborts the conversion, returns to IDLE and forces every output to its reset value. No `pronto` is produced.

## Timing
- The acceptance edge is T.
- CONV occupies edges T+1 through T+27, giving BIN_BITS shifts.
- FIX updates `valor` at edge T+28.
- `pronto` is high during the cycle after edge T+28.
- Total latency is 28 cycles from acceptance to valid `valor`.
- Invalid-digit path: `erro` is set at edge T. `pronto` is high during the cycle after edge T+1.
- `ocupado` is high from edge T through the cycle in which `pronto` is high.
- A new `start` is accepted at the earliest on the edge after `pronto`, which gives a throughput of one conversion per 30 cycles.
- Back-to-back requests must show no residual state from the prior conversion.

## Configuration
- Macro: `DATA_INPUT_SIGN_EN`.
- Defined: `neg` is honoured and negative values are two's-complemented in FIX.
- Undefined:
  - `neg` is ignored and `valor` is always the unsigned magnitude.
  - The negation logic is not synthesised.
  - Latency is unchanged; the FIX state remains.

## Structure
- Package `data_input_pkg` holds:
  - the state enum IDLE/CONV/FIX/DONE;
  - NUM_DIGITS and BIN_BITS constants;
  - a function for the BCD-nibble validity check.
- Sub-module `bcd_digit_adjust` is combinational:
  - 4-bit in, 4-bit out: subtract 3 if ≥ 8, else pass through.
  - Instantiated NUM_DIGITS times in a generate loop inside CONV's datapath.
- Top level holds the FSM, the 5-bit counter, the 59-bit shift register and the sign stage.

## Test plan
- `bcd` = 0x00000123, `neg` = 0 → `pronto` 28 cycles after acceptance, `valor` = 0x0000007B, `erro` = 0.
- `bcd` = 0x99999999, `neg` = 0 → `valor` = 0x05F5E0FF.
- `bcd` = 0x00000045, `neg` = 1 → `valor` = 0xFFFFFFD3 with `DATA_INPUT_SIGN_EN` defined, 0x0000002D without it. `bcd` = 0, `neg` = 1 → `valor` = 0.
- `bcd` = 0x0000001A → `erro` = 1, `pronto` one cycle after the following edge, `valor` unchanged from the previous result.
- `start` re-asserted and `bcd` changed during CONV → ignored; the first result is correct and `ocupado` stays high throughout.
- `reset` pulsed mid-CONV → outputs return to 0 asynchronously, no `pronto`. A subsequent `start` with 0x00000007 → `valor` = 7.

Source files
------------

// File: rtl/data_input_pkg.sv
// Shared types and constants for the data_input BCD-to-binary stage.
// Conversion widths, FSM state encoding and the BCD digit validity check.
package data_input_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned BIN_BITS   = 27;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
  localparam int unsigned SR_W       = BCD_W + BIN_BITS;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned OUT_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // True when every nibble of the packed BCD word is a decimal digit.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/data_input_if.sv
// Request/response bundle between the IN-path controller and data_input.
interface data_input_if;
  import data_input_pkg::*;

  logic             start;
  logic [BCD_W-1:0] bcd;
  logic             neg;
  logic [OUT_W-1:0] valor;
  logic             pronto;
  logic             ocupado;
  logic             erro;

  modport master (
    output start, bcd, neg,
    input  valor, pronto, ocupado, erro
  );

  modport slave (
    input  start, bcd, neg,
    output valor, pronto, ocupado, erro
  );

endinterface

// File: rtl/data_input_bcd_digit_adjust.sv
// One reverse double-dabble digit correction: subtract 3 when the nibble is 8 or more.
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout_c
);

  assign dout_c = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/data_input.sv
// Packed-BCD to 32-bit two's-complement converter (reverse double-dabble, 27 shifts).
// Sign handling is built only when DATA_INPUT_SIGN_EN is defined.
module data_input
  import data_input_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  data_input_if.slave  bus
);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  valor_q, valor_d;
  logic              pronto_q, pronto_d;
  logic              ocupado_q, ocupado_d;
  logic              erro_q, erro_d;

  logic [SR_W-1:0]   shifted;
  logic [BCD_W-1:0]  adj;
  logic [OUT_W-1:0]  mag;
  logic [OUT_W-1:0]  result;

  assign shifted = sr_q >> 1;

  genvar g;
  generate
    for (g = 0; g < int'(NUM_DIGITS); g++) begin : g_adj
      bcd_digit_adjust u_adj (
        .din    (shifted[BIN_BITS + 4*g +: 4]),
        .dout_c (adj[4*g +: 4])
      );
    end
  endgenerate

  assign mag = OUT_W'(sr_q[BIN_BITS-1:0]);

`ifdef DATA_INPUT_SIGN_EN
  logic neg_q, neg_d;

  // Zero magnitude is never negated so -0 comes out as 0.
  assign result = (neg_q && (mag != '0)) ? (~mag + OUT_W'(1)) : mag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) neg_q <= 1'b0;
    else       neg_q <= neg_d;
  end

  always_comb begin
    neg_d = neg_q;
    if ((state_q == IDLE) && bus.start && bcd_valid(bus.bcd)) neg_d = bus.neg;
  end
`else
  assign result = mag;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      cnt_q     <= '0;
      valor_q   <= '0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      valor_q   <= valor_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    valor_d   = valor_q;
    pronto_d  = 1'b0;
    ocupado_d = ocupado_q;
    erro_d    = erro_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ocupado_d = 1'b1;
          if (bcd_valid(bus.bcd)) begin
            sr_d    = {bus.bcd, BIN_BITS'(0)};
            cnt_d   = '0;
            erro_d  = 1'b0;
            state_d = CONV;
          end else begin
            erro_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CONV: begin
        sr_d = {adj, shifted[BIN_BITS-1:0]};
        if (cnt_q == CNT_W'(BIN_BITS - 1)) state_d = FIX;
        else                               cnt_d   = cnt_q + CNT_W'(1);
      end
      FIX: begin
        valor_d  = result;
        pronto_d = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        // Error path arrives with pronto low and spends one cycle raising it.
        if (pronto_q) begin
          ocupado_d = 1'b0;
          state_d   = IDLE;
        end else begin
          pronto_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.valor   = valor_q;
  assign bus.pronto  = pronto_q;
  assign bus.ocupado = ocupado_q;
  assign bus.erro    = erro_q;

endmodule

// File: tb/tb_data_input.sv
// Scoreboard bench for data_input: decimal reference model, random and directed requests.
module tb_data_input;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_input_if bus ();

  data_input dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] valor;
    logic        erro;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [31:0] last_valor = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Decimal value of the digits; invalid digits keep the previous result.
  task automatic model(input logic [31:0] b, input logic n,
                       output logic [31:0] v, output logic e);
    int unsigned m;
    logic [3:0] d;
    m = 0;
    e = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) e = 1'b1;
      m = m * 10 + int'(d);
    end
    if (e) begin
      v = last_valor;
    end else begin
`ifdef DATA_INPUT_SIGN_EN
      v = n ? (32'd0 - 32'(m)) : 32'(m);
`else
      v = 32'(m);
`endif
      last_valor = v;
    end
  endtask

  // Monitor: every pronto pulse must match the oldest outstanding request.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.pronto === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pronto: got pronto=1 expected none (t=%0t)", $time);
      end else begin
        mon_e = sb.pop_front();
        check("valor",   bus.valor, mon_e.valor);
        check("erro",    32'(bus.erro), 32'(mon_e.erro));
        check("latency", 32'(cyc), 32'(mon_e.due));
        check("ocupado_at_pronto", 32'(bus.ocupado), 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] b, input logic n);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (bus.ocupado !== 1'b0) begin
      w++;
      if (w > 100) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: got ocupado=%b expected 0", bus.ocupado);
        return;
      end
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.bcd   = b;
    bus.neg   = n;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    model(b, n, e.valor, e.erro);
    e.due = cyc + (e.erro ? 1 : 28);
    sb.push_back(e);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  logic [31:0] rb;

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bcd   = '0;
    bus.neg   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valor",   bus.valor, 32'd0);
    check("reset_pronto",  32'(bus.pronto), 32'd0);
    check("reset_ocupado", 32'(bus.ocupado), 32'd0);
    check("reset_erro",    32'(bus.erro), 32'd0);
    rst = 1'b0;

    issue(32'h0000_0123, 1'b0);
    issue(32'h9999_9999, 1'b0);
    issue(32'h0000_0000, 1'b1);
    issue(32'h0000_0045, 1'b1);
    issue(32'h0000_001A, 1'b0);
    drain();
    @(negedge clk);
    check("erro_held", 32'(bus.erro), 32'd1);

    // start and bcd churn during CONV must be ignored
    issue(32'h0000_0456, 1'b0);
    repeat (10) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.bcd   = $urandom;
      bus.neg   = 1'b1;
      check("ocupado_conv", 32'(bus.ocupado), 32'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // asynchronous reset in the middle of a conversion
    issue(32'h0000_0055, 1'b0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_valor",   bus.valor, 32'd0);
    check("midrst_pronto",  32'(bus.pronto), 32'd0);
    check("midrst_ocupado", 32'(bus.ocupado), 32'd0);
    check("midrst_erro",    32'(bus.erro), 32'd0);
    sb.delete();
    last_valor = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'h0000_0007, 1'b0);
    drain();

    for (int k = 0; k < 40; k++) begin
      rb = '0;
      for (int i = 0; i < 8; i++) rb[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) rb[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      issue(rb, 1'($urandom_range(0, 1)));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
